regfile_operand_stage: RTL and testbench

REGFILE_OPERAND_STAGE -- requirements
Module: regfile_operand_stage

---
 rtl/proc32_pkg.sv | 14 +
 rtl/regfile32.sv | 35 +++
 rtl/regfile_operand_stage.sv | 90 +++++++++
 tb/tb_regfile_operand_stage.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/proc32_pkg.sv
// Shared constants and FSM state type for the 32-register operand-fetch slice.
package proc32_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } opstate_t;

endpackage

// File: rtl/regfile32.sv
// 2-read / 1-write register array; register ZERO_REG is hardwired to zero.
module regfile32
    import proc32_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr1,
    input  logic [AW-1:0] raddr2,
    output logic [DW-1:0] rdata1,
    output logic [DW-1:0] rdata2
);

    logic [DW-1:0] regs [NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != AW'(ZERO_REG))) begin
            regs[waddr] <= wdata;
        end
    end

    // Reads return the stored (pre-write) value; forwarding lives in the stage.
    assign rdata1 = (raddr1 == AW'(ZERO_REG)) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == AW'(ZERO_REG)) ? '0 : regs[raddr2];

endmodule

// File: rtl/regfile_operand_stage.sv
// Operand-fetch stage: register file read into a one-entry output pipeline.
// Define REGFILE_BYPASS_EN to forward a same-cycle write into the captured operand.
module regfile_operand_stage #(
    parameter int DATA_W = proc32_pkg::DATA_W,
    parameter int ADDR_W = proc32_pkg::ADDR_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_W-1:0]      rs1_addr,
    input  logic [ADDR_W-1:0]      rs2_addr,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      waddr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [DATA_W-1:0]      op1,
    output logic [DATA_W-1:0]      op2,
    output proc32_pkg::opstate_t   dbg_state
);

    import proc32_pkg::*;

    // Handshake: a transfer happens on an edge where valid && ready are both 1.
    // req_ready may depend combinationally on op_ready; op_valid comes from state only.

    opstate_t          state;
    opstate_t          state_nxt;
    logic              accept;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;

    regfile32 #(
        .DW (DATA_W),
        .AW (ADDR_W)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr1 (rs1_addr),
        .raddr2 (rs2_addr),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

`ifdef REGFILE_BYPASS_EN
    assign src1 = (we && (waddr == rs1_addr) && (rs1_addr != ADDR_W'(ZERO_REG))) ? wdata : rd1;
    assign src2 = (we && (waddr == rs2_addr) && (rs2_addr != ADDR_W'(ZERO_REG))) ? wdata : rd2;
`else
    assign src1 = rd1;
    assign src2 = rd2;
`endif

    assign op_valid  = (state == ST_FULL);
    assign req_ready = !op_valid || op_ready;
    assign accept    = req_valid && req_ready;
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_EMPTY: if (accept) state_nxt = ST_FULL;
            ST_FULL: begin
                if (accept)        state_nxt = ST_FULL;
                else if (op_ready) state_nxt = ST_EMPTY;
            end
        endcase
    end

    // Operands are a snapshot taken only on accept, so later writes cannot disturb them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
            op1   <= '0;
            op2   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op1 <= src1;
                op2 <= src2;
            end
        end
    end

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Bench for regfile_operand_stage: directed scenarios plus random traffic against a queue-based model.
module tb_regfile_operand_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] rs1_addr;
    logic [AW-1:0] rs2_addr;
    logic          we;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          op_valid;
    logic          op_ready;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    proc32_pkg::opstate_t dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   model_rf[32];

`ifdef REGFILE_BYPASS_EN
    localparam logic [DW-1:0] EXP_R7 = 32'hAAAA_5555;
`else
    localparam logic [DW-1:0] EXP_R7 = 32'h1111_2222;
`endif

    regfile_operand_stage dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op1       (op1),
        .op2       (op2),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // driver: inputs change 1 time unit after the edge, then wait to mid-cycle
    task automatic step(input logic r, input logic rv, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic w, input logic [AW-1:0] wa,
                        input logic [DW-1:0] wd, input logic ordy);
        @(posedge clk);
        #1;
        rst = r; req_valid = rv; rs1_addr = a1; rs2_addr = a2;
        we = w; waddr = wa; wdata = wd; op_ready = ordy;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, ordy);
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        step(1'b0, 1'b0, '0, '0, 1'b1, wa, wd, 1'b1);
    endtask

    task automatic req(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input logic ordy);
        step(1'b0, 1'b1, a1, a2, 1'b0, '0, '0, ordy);
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = (a == 0) ? '0 : model_rf[a];
`ifdef REGFILE_BYPASS_EN
        if (we && waddr == a && a != 0) v = wdata;
`endif
        return v;
    endfunction

    // monitor + reference model: check what is presented, then predict the coming edge
    initial begin
        bit acc;
        for (int i = 0; i < 32; i++) model_rf[i] = '0;
        forever begin
            @(negedge clk);
            chk("req_ready", {63'd0, req_ready}, {63'd0, (exp_q.size() == 0) || op_ready});
            chk("op_valid", {63'd0, op_valid}, {63'd0, exp_q.size() != 0});
            if (exp_q.size() != 0 && op_valid === 1'b1)
                chk("pair", {op1, op2}, exp_q[0]);
            if (rst) begin
                exp_q.delete();
                for (int i = 0; i < 32; i++) model_rf[i] = '0;
            end else begin
                acc = req_valid && ((exp_q.size() == 0) || op_ready);
                if (exp_q.size() != 0 && op_ready) void'(exp_q.pop_front());
                if (acc) exp_q.push_back({model_read(rs1_addr), model_read(rs2_addr)});
                if (we && waddr != 0) model_rf[waddr] = wdata;
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
        we = 1'b0; waddr = '0; wdata = '0; op_ready = 1'b0;
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        chk("rst_op_valid", {63'd0, op_valid}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_ops", {op1, op2}, 64'd0);

        // basic fetch with latency 1, then snapshot under backpressure
        wr(5'd5, 32'h0000_F0F0);
        wr(5'd6, 32'h0F0F_0000);
        req(5'd5, 5'd6, 1'b1);
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 32'h1234_5678, 1'b0);
        chk("basic_valid", {63'd0, op_valid}, 64'd1);
        chk("basic_pair", {op1, op2}, {32'h0000_F0F0, 32'h0F0F_0000});
        req(5'd5, 5'd5, 1'b0);
        chk("hold_op1", {32'd0, op1}, {32'd0, 32'h0000_F0F0});
        chk("hold_ready", {63'd0, req_ready}, 64'd0);
        req(5'd5, 5'd0, 1'b1);
        idle(1'b1);
        chk("after_hold_op1", {32'd0, op1}, {32'd0, 32'h1234_5678});

        // register 0 stays zero
        wr(5'd0, 32'hFFFF_FFFF);
        req(5'd0, 5'd0, 1'b1);
        idle(1'b1);
        chk("zero_reg", {op1, op2}, 64'd0);

        // write and accept of the same register on one edge
        wr(5'd7, 32'h1111_2222);
        step(1'b0, 1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'hAAAA_5555, 1'b1);
        idle(1'b1);
        chk("bypass_op1", {32'd0, op1}, {32'd0, EXP_R7});

        // back-to-back stream without bubbles
        for (int i = 8; i < 16; i++) wr(AW'(i), 32'h0101_0101 * i);
        req(5'd8, 5'd9, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            if (k < 4) req(AW'(8 + 2 * k), AW'(9 + 2 * k), 1'b1);
            else       idle(1'b1);
            chk("b2b_valid", {63'd0, op_valid}, 64'd1);
            chk("b2b_pair", {op1, op2},
                {32'h0101_0101 * (8 + 2 * (k - 1)), 32'h0101_0101 * (9 + 2 * (k - 1))});
        end

        // reset while a pair is pending
        req(5'd5, 5'd6, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        idle(1'b0);
        chk("midrst_valid", {63'd0, op_valid}, 64'd0);
        chk("midrst_ready", {63'd0, req_ready}, 64'd1);
        req(5'd5, 5'd6, 1'b1);
        idle(1'b1);
        chk("midrst_r5", {op1, op2}, 64'd0);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 3) != 0);
        end
        idle(1'b1);
        idle(1'b1);
        chk("drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
